led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised next-generation running-light engine for the board LED bank. It drives N_LEDS outputs from a selectable set of eight patterns, stepping at a runtime-programmable tick period. It sits between the 10 Hz system clock domain and the LED pins, replacing the fixed 26-LED, fixed-rate, 4-mode running light. New over that block: hold/freeze, a step strobe, a ping-pong chase, reverse fill, binary count and explicit mode acknowledge.

## Interface
- N_LEDS, 26: LED count; legal range 8..64.
- WIN, 8: active pattern window, led[WIN-1:0]; must be even, 2..N_LEDS.
- DIV_W, 4: width of period input.
- Clk  in  1  system clock (10 Hz on board).
- Rst  in  1  reset, asynchronous, active-high.
- light_mode  in  3  pattern select.
- period  in  DIV_W  clocks per pattern step; 0 is treated as 1.
- hold  in  1  freezes tick counter and pattern.
- led  out  N_LEDS  LED drive, registered.
- step  out  1  one-cycle pulse, high in the cycle a pattern step becomes visible on led.
- mode_ack  out  3  currently active mode, registered.

## Operation
- Reset: led=0, step=0, mode_ack=0, cnt=1, step counter s=0, toggle=0, chase pos=0, dir=up, LFSR=16'hACE1.
- Mode switch: checked every cycle, with priority over hold and tick.
  - Trigger: light_mode != mode_ack.
  - Effect: led=0, s=0, toggle=0, pos=0, dir=up, cnt=1, step=0, mode_ack<=light_mode.
- Tick: eff = (period==0) ? 1 : period.
  - When hold=0: if cnt >= eff, perform one action, cnt<=1, step<=1; else cnt<=cnt+1, step<=0.
  - When hold=1: cnt, s and led are unchanged and step=0.
- Window: led[N_LEDS-1:WIN] forced 0 on every action, except in mode 6.
- Modes, one action each:
  - 0 alternate: window <= toggle ? 1010..10 : 0101..01 (bit0 set first); toggle inverts.
  - 1 fill/drain: s in 0..2*WIN-1. If s<WIN, led[s]<=1; else led[s-WIN]<=0. s wraps to 0.
  - 2 symmetric: s in 0..WIN-1. If s<WIN/2, led[s] and led[WIN-1-s] <=1; else led[s-WIN/2] and led[WIN-1-(s-WIN/2)] <=0. s wraps to 0.
  - 3 ping-pong: window is one-hot at pos, first action lights led[0].
    - pos steps up to WIN-1, then down to 0; the ends are not repeated.
    - For WIN=2, pos alternates 0,1.
  - 4 reverse fill/drain: as mode 1 with index WIN-1-(s mod WIN).
  - 5 binary: window <= s (WIN bits), then s<=s+1 with natural wrap.
  - 6 random: led[lfsr % N_LEDS] toggles. Spans all N_LEDS.
  - 7 off: led=0; step never pulses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle unless Rst, including during hold.

## Timing
- Mode switch in cycle T: led=0 at T+1. First action visible at T+1+eff.
- Steady state: one action every eff cycles. step is coincident with the led update.
- period change: applies at the next comparison. If cnt > new eff, the action fires on the next non-hold cycle.
- hold toggling: no action is lost or duplicated; the counter resumes from its frozen value.
- Rst asserted mid-pattern: immediate return to reset values.
  - If light_mode != 0 at release, the first cycle after release is a mode switch.
- No combinational path from inputs to outputs.

## Configuration
- LED_SEQ_RANDOM_EN defined: mode 6 as specified, LFSR instantiated.
- LED_SEQ_RANDOM_EN undefined: no LFSR logic; mode 6 behaves exactly as mode 7; mode_ack still reports 6.

## Structure
- Shared package led_seq_pkg holds:
  - the mode encodings MODE_ALT..MODE_OFF;
  - the LFSR seed 16'hACE1 and tap constants;
  - the default N_LEDS and WIN.
- One sub-module led_seq_lfsr (16-bit LFSR, Clk/Rst/q). Instantiated only under LED_SEQ_RANDOM_EN.
- All other logic stays in led_sequencer.

## Test plan
- Mode 0, period=2, N_LEDS=26, WIN=8: led=0x55 at switch+3, then 0xAA two cycles later. led[25:8]=0 throughout; step pulses every 2 cycles.
- Mode 1, period=1: led sequence 0x01,0x03…0xFF,0xFE,0xFC…0x00, then repeats. Mode 4 gives 0x80,0xC0…
- Mode 3, WIN=8, period=1: pos sequence 0,1..7,6..0,1.
  - Assert hold for 5 cycles at pos=5: led and step frozen, next action gives pos=6.
- Mode 5, period=0: behaves as period=1. After 256 actions led returns to 0x00.
- Mode 2→0 switch mid-pattern, then Rst mid-pattern: led=0 next cycle and mode_ack updates. Reset yields all outputs 0.
- Mode 6: toggled index matches the reference-model LFSR from seed 0xACE1 modulo 26.
  - Rebuild without LED_SEQ_RANDOM_EN: led stays 0 and step never pulses.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants for the LED running-light engine: mode encodings,
// LFSR seed/taps and default geometry.
package led_seq_pkg;

    // Pattern select encodings, also reported back on mode_ack
    typedef enum logic [2:0] {
        MODE_ALT   = 3'd0,
        MODE_FILL  = 3'd1,
        MODE_SYM   = 3'd2,
        MODE_PING  = 3'd3,
        MODE_RFILL = 3'd4,
        MODE_BIN   = 3'd5,
        MODE_RAND  = 3'd6,
        MODE_OFF   = 3'd7
    } mode_e;

    // 16-bit right-shifting Fibonacci LFSR; taps 16,14,13,11 land on bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned DEFAULT_N_LEDS = 26;
    localparam int unsigned DEFAULT_WIN    = 8;
    localparam int unsigned DEFAULT_DIV_W  = 4;

    // Next LFSR state: feedback shifts in at the top
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/led_seq_lfsr.sv
// Free-running 16-bit LFSR used by the random pattern mode.
module led_seq_lfsr
    import led_seq_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    output logic [15:0] q
);

    // Advance every cycle; reseed on reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Running-light engine: eight selectable patterns stepped at a programmable
// tick period, with hold, step strobe and mode acknowledge.
// Optional feature macro: LED_SEQ_RANDOM_EN enables the random mode (6) and
// its LFSR; without it mode 6 behaves as mode 7 (off).
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS = DEFAULT_N_LEDS,
    parameter int unsigned WIN    = DEFAULT_WIN,
    parameter int unsigned DIV_W  = DEFAULT_DIV_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [2:0]        light_mode,
    input  logic [DIV_W-1:0]  period,
    input  logic              hold,
    output logic [N_LEDS-1:0] led,
    output logic              step,
    output logic [2:0]        mode_ack
);

    // Index into the window; one extra bit covers the 0..2*WIN-1 step range
    localparam int unsigned IDX_W = $clog2(WIN);
    localparam int unsigned SI_W  = IDX_W + 1;
    localparam int unsigned HALF  = WIN / 2;
    localparam logic [WIN-1:0] ALT_LO = {HALF{2'b01}};

    // Step counter is WIN bits wide: enough for 2*WIN-1 and the binary count
    logic [WIN-1:0]   s;
    logic [DIV_W-1:0] cnt;
    logic             toggle;
    logic [IDX_W-1:0] pos;
    logic             dir;

    logic [DIV_W-1:0]  eff;
    logic [WIN-1:0]    win_n;
    logic [N_LEDS-1:0] led_n;
    logic [WIN-1:0]    s_n;
    logic              toggle_n;
    logic [IDX_W-1:0]  pos_n;
    logic              dir_n;
    logic              pulse_n;
    logic [SI_W-1:0]   s_lo;
    logic [SI_W-1:0]   f_idx;
    logic              f_set;
    logic [SI_W-1:0]   h_idx;
    logic              h_set;

`ifdef LED_SEQ_RANDOM_EN
    localparam int unsigned NIDX_W = $clog2(N_LEDS);
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_mod;
    logic [NIDX_W-1:0] rand_idx;

    led_seq_lfsr u_lfsr (
        .Clk (Clk),
        .Rst (Rst),
        .q   (lfsr_q)
    );

    // Bank position toggled by the random mode
    always_comb begin
        lfsr_mod = lfsr_q % 16'(N_LEDS);
        rand_idx = NIDX_W'(lfsr_mod);
    end
`endif

    // Effective tick period: zero behaves as one
    always_comb begin
        eff = (period == '0) ? DIV_W'(1) : period;
    end

    // Next pattern and sequencing state for one action of the current mode
    always_comb begin
        win_n    = led[WIN-1:0];
        led_n    = '0;
        s_n      = s;
        toggle_n = toggle;
        pos_n    = pos;
        dir_n    = dir;
        pulse_n  = 1'b1;
        s_lo     = SI_W'(s);

        // Fill/drain phase: first WIN steps set, next WIN steps clear
        if (s_lo < SI_W'(WIN)) begin
            f_idx = s_lo;
            f_set = 1'b1;
        end else begin
            f_idx = s_lo - SI_W'(WIN);
            f_set = 1'b0;
        end

        // Symmetric phase: first half sets pairs, second half clears them
        if (s_lo < SI_W'(HALF)) begin
            h_idx = s_lo;
            h_set = 1'b1;
        end else begin
            h_idx = s_lo - SI_W'(HALF);
            h_set = 1'b0;
        end

        case (mode_e'(mode_ack))
            MODE_ALT: begin
                win_n    = toggle ? ~ALT_LO : ALT_LO;
                toggle_n = ~toggle;
            end
            MODE_FILL: begin
                win_n[IDX_W'(f_idx)] = f_set;
                s_n = (s_lo == SI_W'(2*WIN-1)) ? '0 : s + WIN'(1);
            end
            MODE_RFILL: begin
                win_n[IDX_W'(SI_W'(WIN-1) - f_idx)] = f_set;
                s_n = (s_lo == SI_W'(2*WIN-1)) ? '0 : s + WIN'(1);
            end
            MODE_SYM: begin
                win_n[IDX_W'(h_idx)]                = h_set;
                win_n[IDX_W'(SI_W'(WIN-1) - h_idx)] = h_set;
                s_n = (s_lo == SI_W'(WIN-1)) ? '0 : s + WIN'(1);
            end
            MODE_PING: begin
                win_n      = '0;
                win_n[pos] = 1'b1;
                // Bounce at the ends without repeating the end position
                if (!dir) begin
                    if (pos == IDX_W'(WIN-1)) begin
                        dir_n = 1'b1;
                        pos_n = IDX_W'(WIN-2);
                    end else begin
                        pos_n = pos + IDX_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        dir_n = 1'b0;
                        pos_n = IDX_W'(1);
                    end else begin
                        pos_n = pos - IDX_W'(1);
                    end
                end
            end
            MODE_BIN: begin
                win_n = s;
                s_n   = s + WIN'(1);
            end
`ifdef LED_SEQ_RANDOM_EN
            MODE_RAND: begin
                win_n = led[WIN-1:0];
            end
`else
            MODE_RAND: begin
                win_n   = '0;
                pulse_n = 1'b0;
            end
`endif
            default: begin
                win_n   = '0;
                pulse_n = 1'b0;
            end
        endcase

        // Everything above the window is cleared on each action
        led_n = N_LEDS'(win_n);
`ifdef LED_SEQ_RANDOM_EN
        if (mode_e'(mode_ack) == MODE_RAND) begin
            led_n = led ^ (N_LEDS'(1) << rand_idx);
        end
`endif
    end

    // Mode switch, hold and tick handling with registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            led      <= '0;
            step     <= 1'b0;
            mode_ack <= 3'd0;
            cnt      <= DIV_W'(1);
            s        <= '0;
            toggle   <= 1'b0;
            pos      <= '0;
            dir      <= 1'b0;
        end else if (light_mode != mode_ack) begin
            led      <= '0;
            step     <= 1'b0;
            mode_ack <= light_mode;
            cnt      <= DIV_W'(1);
            s        <= '0;
            toggle   <= 1'b0;
            pos      <= '0;
            dir      <= 1'b0;
        end else if (hold) begin
            step <= 1'b0;
        end else if (cnt >= eff) begin
            cnt    <= DIV_W'(1);
            led    <= led_n;
            step   <= pulse_n;
            s      <= s_n;
            toggle <= toggle_n;
            pos    <= pos_n;
            dir    <= dir_n;
        end else begin
            cnt  <= cnt + DIV_W'(1);
            step <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed table-driven bench for led_sequencer (N_LEDS=26, WIN=8, DIV_W=4).
module tb_led_sequencer;

    logic        Clk;
    logic        Rst;
    logic [2:0]  light_mode;
    logic [3:0]  period;
    logic        hold;
    logic [25:0] led;
    logic        step;
    logic [2:0]  mode_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [3:0]  period;
        logic        hold;
        logic [25:0] led;
        logic        step;
        logic [2:0]  ack;
    } vec_t;

    vec_t vecs[$];

    led_sequencer #(.N_LEDS(26), .WIN(8), .DIV_W(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .light_mode (light_mode),
        .period     (period),
        .hold       (hold),
        .led        (led),
        .step       (step),
        .mode_ack   (mode_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

`ifdef LED_SEQ_RANDOM_EN
    // Reference LFSR from the documented seed and taps
    logic [15:0] ref_lfsr;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] m, input logic [3:0] p, input logic h,
                       input logic [25:0] l, input logic st, input logic [2:0] a);
        vec_t v;
        v.mode = m; v.period = p; v.hold = h; v.led = l; v.step = st; v.ack = a;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int pp [16];
        logic [25:0] exp_led;
        logic        exp_step;
        int          idx;

        Rst = 1'b1; light_mode = 3'd7; period = 4'd1; hold = 1'b0;

        // Off, then mode 0 at period 2 with a hold in the middle
        add(7, 1, 0, 26'h0, 0, 7);
        add(7, 1, 0, 26'h0, 0, 7);
        add(0, 2, 0, 26'h0, 0, 0);
        add(0, 2, 0, 26'h0, 0, 0);
        add(0, 2, 0, 26'h55, 1, 0);
        add(0, 2, 0, 26'h55, 0, 0);
        add(0, 2, 0, 26'hAA, 1, 0);
        add(0, 2, 0, 26'hAA, 0, 0);
        add(0, 2, 0, 26'h55, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 2, 1, 26'h55, 0, 0);
        add(0, 2, 0, 26'h55, 0, 0);
        add(0, 2, 0, 26'hAA, 1, 0);
        // Mode 1 fill then drain, then wrap
        add(1, 1, 0, 26'h0, 0, 1);
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 26'((1 << k) - 1), 1, 1);
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 26'((32'hFF << k) & 32'hFF), 1, 1);
        add(1, 1, 0, 26'h01, 1, 1);
        // Mode 4 reverse fill then drain
        add(4, 1, 0, 26'h0, 0, 4);
        for (int k = 1; k <= 8; k++) add(4, 1, 0, 26'((32'hFF00 >> k) & 32'hFF), 1, 4);
        for (int k = 1; k <= 8; k++) add(4, 1, 0, 26'(32'hFF >> k), 1, 4);
        // Mode 2 symmetric
        add(2, 1, 0, 26'h0, 0, 2);
        add(2, 1, 0, 26'h81, 1, 2);
        add(2, 1, 0, 26'hC3, 1, 2);
        add(2, 1, 0, 26'hE7, 1, 2);
        add(2, 1, 0, 26'hFF, 1, 2);
        add(2, 1, 0, 26'h7E, 1, 2);
        add(2, 1, 0, 26'h3C, 1, 2);
        add(2, 1, 0, 26'h18, 1, 2);
        add(2, 1, 0, 26'h00, 1, 2);
        add(2, 1, 0, 26'h81, 1, 2);
        // Mode 0 at period 4, period shortened while cnt=3, then period 0
        add(0, 4, 0, 26'h0, 0, 0);
        add(0, 4, 0, 26'h0, 0, 0);
        add(0, 4, 0, 26'h0, 0, 0);
        add(0, 1, 0, 26'h55, 1, 0);
        add(0, 1, 0, 26'hAA, 1, 0);
        add(0, 0, 0, 26'h55, 1, 0);
        // Mode 3 ping-pong with a 5-cycle hold at pos 5
        add(3, 1, 0, 26'h0, 0, 3);
        pp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        for (int k = 0; k < 6; k++) add(3, 1, 0, 26'(1 << pp[k]), 1, 3);
        for (int k = 0; k < 5; k++) add(3, 1, 1, 26'h20, 0, 3);
        for (int k = 6; k < 16; k++) add(3, 1, 0, 26'(1 << pp[k]), 1, 3);
        // Off mode never pulses
        for (int k = 0; k < 4; k++) add(7, 1, 0, 26'h0, 0, 7);

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("reset led", 64'(led), 64'h0);
        chk("reset step", 64'(step), 64'h0);
        chk("reset ack", 64'(mode_ack), 64'h0);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            light_mode = vecs[i].mode;
            period     = vecs[i].period;
            hold       = vecs[i].hold;
            cyc();
            chk($sformatf("row%0d led", i), 64'(led), 64'(vecs[i].led));
            chk($sformatf("row%0d step", i), 64'(step), 64'(vecs[i].step));
            chk($sformatf("row%0d ack", i), 64'(mode_ack), 64'(vecs[i].ack));
        end

        // Mode 2 -> 0 switch mid-pattern
        light_mode = 3'd2; period = 4'd1; hold = 1'b0;
        cyc();
        chk("m2 switch ack", 64'(mode_ack), 64'd2);
        cyc();
        chk("m2 a1", 64'(led), 64'h81);
        cyc();
        chk("m2 a2", 64'(led), 64'hC3);
        light_mode = 3'd0;
        cyc();
        chk("m2to0 led", 64'(led), 64'h0);
        chk("m2to0 ack", 64'(mode_ack), 64'd0);
        chk("m2to0 step", 64'(step), 64'd0);
        cyc();
        chk("m0 a1", 64'(led), 64'h55);

        // Asynchronous reset mid-pattern, released with mode 5 selected
        light_mode = 3'd5; period = 4'd0;
        Rst = 1'b1;
        #1;
        chk("async rst led", 64'(led), 64'h0);
        chk("async rst step", 64'(step), 64'h0);
        chk("async rst ack", 64'(mode_ack), 64'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        cyc();
        chk("post rst ack", 64'(mode_ack), 64'd5);
        chk("post rst led", 64'(led), 64'h0);

        // Binary count at period 0 wraps after 256 actions
        for (int k = 1; k <= 257; k++) begin
            cyc();
            chk($sformatf("bin%0d led", k), 64'(led), 64'((k - 1) & 255));
            chk($sformatf("bin%0d step", k), 64'(step), 64'h1);
        end

        // Random mode
        light_mode = 3'd6; period = 4'd1;
        cyc();
        chk("m6 ack", 64'(mode_ack), 64'd6);
        chk("m6 switch led", 64'(led), 64'h0);
        exp_led = '0;
        for (int k = 0; k < 24; k++) begin
            hold = (k == 10 || k == 11);
`ifdef LED_SEQ_RANDOM_EN
            if (!hold) begin
                idx = int'(ref_lfsr) % 26;
                exp_led = exp_led ^ (26'(1) << idx);
            end
            exp_step = !hold;
`else
            idx = 0;
            exp_step = 1'b0;
`endif
            cyc();
            chk($sformatf("m6 %0d led", k), 64'(led), 64'(exp_led));
            chk($sformatf("m6 %0d step", k), 64'(step), 64'(exp_step));
        end
        hold = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
